// File: rtl/cbuf_ctl_arbiter.sv
// Round-robin arbiter driving a dual-rail, four-phase RTZ control token into a conditional buffer.
// Define CBUF_ARB_SYNC_EN for a 2-flop ack synchroniser; otherwise a single flop is used.
module cbuf_ctl_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_bit,
    output logic [1:0]      ctl,
    input  logic            ctl_ack,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            err
);

    localparam int IW = $clog2(NREQ);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DRIVE, RTZ, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [7:0]    cnt;
    logic          ack_s;

    // ---- ack synchroniser stage ----
`ifdef CBUF_ARB_SYNC_EN
    logic ack_p0;
    logic ack_p1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ack_p0 <= 1'b0;
            ack_p1 <= 1'b0;
        end else begin
            ack_p0 <= ctl_ack;
            ack_p1 <= ack_p0;
        end
    end

    assign ack_s = ack_p1;
`else
    logic ack_p0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ack_p0 <= 1'b0;
        end else begin
            ack_p0 <= ctl_ack;
        end
    end

    assign ack_s = ack_p0;
`endif

    // Search upward from the slot after the last winner, wrapping.
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // ---- handshake FSM stage ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            ctl   <= 2'b00;
            gnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            last  <= IW'(NREQ - 1);
            win   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (found) begin
                        win   <= pick;
                        ctl   <= req_bit[pick] ? 2'b10 : 2'b01;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (ack_s) begin
                        ctl   <= 2'b00;
                        cnt   <= '0;
                        state <= RTZ;
                    end else if (cnt == TO_LIM) begin
                        err   <= 1'b1;
                        ctl   <= 2'b00;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RTZ: begin
                    if (!ack_s) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        last  <= win;
                        cnt   <= '0;
                        state <= DONE;
                    end else if (cnt == TO_LIM) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // One dead cycle lets the winner drop req before the next arbitration.
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbuf_ctl_arbiter.sv
// Directed self-checking bench for cbuf_ctl_arbiter; the bench acts as the buffer, driving ctl_ack by hand.
`timescale 1ns/1ps
module tb_cbuf_ctl_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
`ifdef CBUF_ARB_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] req_bit = '0;
    logic       ctl_ack = 1'b0;
    logic [1:0] ctl;
    logic [3:0] gnt;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cbuf_ctl_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (req),
        .req_bit (req_bit),
        .ctl     (ctl),
        .ctl_ack (ctl_ack),
        .gnt     (gnt),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET   = 1'b0;
        ctl_ack = 1'b0;
        req     = '0;
        #1;
        chk("rst ctl", ctl, 2'b00);
        chk("rst gnt", gnt, 4'b0000);
        chk("rst busy", busy, 1'b0);
        chk("rst err", err, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Buffer side: ack 3 cycles after the token appears, release 3 cycles after neutral.
    // Latency counts are in negedges from the ack change: one sampling edge plus SYNC.
    task automatic handshake(input string tag, input logic [1:0] exp_ctl,
                             input logic [3:0] exp_gnt, input logic [3:0] req_after);
        int n;
        n = 0;
        while (ctl == 2'b00 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, " token"}, ctl, exp_ctl);
        chk({tag, " busy"}, busy, 1'b1);
        repeat (3) @(negedge CLK);
        chk({tag, " token held"}, ctl, exp_ctl);
        ctl_ack = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ctl != 2'b00 && n < 20);
        chk({tag, " ctl fall latency"}, n, SYNC + 1);
        chk({tag, " no early gnt"}, gnt, 4'b0000);
        repeat (3) @(negedge CLK);
        ctl_ack = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (gnt == 4'b0000 && n < 20);
        chk({tag, " gnt latency"}, n, SYNC + 1);
        chk({tag, " gnt"}, gnt, exp_gnt);
        chk({tag, " busy in done"}, busy, 1'b1);
        req = req_after;
        @(negedge CLK);
        chk({tag, " gnt one cycle"}, gnt, 4'b0000);
        chk({tag, " busy after done"}, busy, 1'b0);
    endtask

    initial begin
        int n;

        // Single requester, bit 0 token
        do_reset();
        req_bit = 4'b0000;
        req     = 4'b0001;
        handshake("single", 2'b01, 4'b0001, 4'b0000);
        chk("single err", err, 1'b0);

        // All requesting: strict rotation 0,1,2,3 with alternating tokens
        do_reset();
        req_bit = 4'b1010;
        req     = 4'b1111;
        handshake("rr0", 2'b01, 4'b0001, 4'b1110);
        handshake("rr1", 2'b10, 4'b0010, 4'b1100);
        handshake("rr2", 2'b01, 4'b0100, 4'b1000);
        handshake("rr3", 2'b10, 4'b1000, 4'b0000);

        // Wrap: pointer at 1 with only 0 and 1 requesting returns to 0
        do_reset();
        req_bit = 4'b1010;
        req     = 4'b0011;
        handshake("wrap0", 2'b01, 4'b0001, 4'b0011);
        handshake("wrap1", 2'b10, 4'b0010, 4'b0011);
        handshake("wrap2", 2'b01, 4'b0001, 4'b0000);

        // Timeout: ack never arrives
        do_reset();
        req_bit = 4'b0010;
        req     = 4'b0001;
        @(negedge CLK);
        chk("to token", ctl, 2'b01);
        repeat (15) @(negedge CLK);
        chk("to err before limit", err, 1'b0);
        chk("to ctl before limit", ctl, 2'b01);
        @(negedge CLK);
        chk("to err", err, 1'b1);
        chk("to ctl", ctl, 2'b00);
        chk("to gnt", gnt, 4'b0000);
        chk("to busy", busy, 1'b0);

        // Same requester retries and succeeds; err stays sticky
        req = 4'b1111;
        handshake("retry", 2'b01, 4'b0001, 4'b1111);
        chk("retry err sticky", err, 1'b1);

        // Next winner is 1; reset while in RTZ
        n = 0;
        while (ctl == 2'b00 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("mid token", ctl, 2'b10);
        ctl_ack = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ctl != 2'b00 && n < 20);
        chk("mid in rtz busy", busy, 1'b1);
        RESET   = 1'b0;
        ctl_ack = 1'b0;
        #1;
        chk("async rst ctl", ctl, 2'b00);
        chk("async rst gnt", gnt, 4'b0000);
        chk("async rst busy", busy, 1'b0);
        chk("async rst err", err, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        handshake("post rst", 2'b01, 4'b0001, 4'b0000);
        chk("post rst err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
